operand_regfile: RTL and testbench

Operand register file that serves the operand controller's read-address/read-data protocol. It accepts one read address per cycle on a valid/ready handshake and returns the addressed word a fixed RD_LATENCY cycles later on a valid-only data port. The data port has no back-pressure. A separate write port loads operands from the writeback path. After reset, an init sequencer clears every entry before the first read is accepted.

---
 rtl/config_pkg.sv | 22 ++
 rtl/regfile_rd_pipe.sv | 51 +++++
 rtl/operand_regfile.sv | 106 ++++++++++
 tb/tb_operand_regfile.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared configuration for the operand datapath: word and address types,
// plus the register-file sequencer states.
package config_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // INIT clears the array after reset; RUN serves reads and writes.
  typedef enum logic {
    INIT,
    RUN
  } regfile_state_t;

  // True when an address selects a real entry of a DEPTH-entry array.
  function automatic logic addr_in_range(input addr_t addr, input int depth);
    return int'(addr) < depth;
  endfunction

endpackage

// File: rtl/regfile_rd_pipe.sv
// Fixed-latency return pipeline for register-file reads. Carries
// {valid, err, data} through LATENCY stages; data stages only load when
// their input is valid, so the output word holds between returns.
module regfile_rd_pipe
  import config_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic  clk,
  input  logic  arst,
  input  logic  in_valid,
  input  logic  in_err,
  input  data_t in_data,
  output logic  out_valid,
  output logic  out_err,
  output data_t out_data
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] err_q;
  data_t              data_q [LATENCY];

  // Shift the request through the stages; reset drops everything in flight.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid && in_err;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_err   = err_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/operand_regfile.sv
// Operand register file: single-ported flop array with a valid/ready read
// address port, a fixed-latency valid-only read data port and a write port
// from writeback. After reset an init sequencer zeroes every entry.
module operand_regfile
  import config_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic  clk_i,
  input  logic  arst_i,
  input  addr_t rd_addr_i,
  input  logic  rd_addr_valid_i,
  output logic  rd_addr_ready_o,
  output data_t rd_data_o,
  output logic  rd_data_valid_o,
  output logic  rd_err_o,
  input  addr_t wr_addr_i,
  input  data_t wr_data_i,
  input  logic  wr_valid_i,
  output logic  wr_ready_o,
  output logic  init_done_o
);

  localparam int CNT_W = $clog2(DEPTH);

  typedef logic [CNT_W-1:0] idx_t;

  regfile_state_t state_q;
  regfile_state_t state_d;
  idx_t           clr_cnt_q;
  logic           clr_last;
  data_t          mem [DEPTH];

  logic  running;
  logic  wr_fire;
  logic  wr_in_range;
  logic  rd_fire;
  logic  rd_in_range;
  data_t rd_word;

  assign running  = (state_q == RUN);
  assign clr_last = (clr_cnt_q == idx_t'(DEPTH - 1));

  // A write owns the single array port, so it blocks any read that cycle.
  assign wr_ready_o      = running;
  assign rd_addr_ready_o = running && !wr_valid_i;
  assign init_done_o     = running;

  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign wr_in_range = addr_in_range(wr_addr_i, DEPTH);
  assign rd_fire     = rd_addr_valid_i && rd_addr_ready_o;
  assign rd_in_range = addr_in_range(rd_addr_i, DEPTH);

  // Sequencer state and clear counter; reset always restarts the clear.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT && !clr_last) begin
        clr_cnt_q <= clr_cnt_q + idx_t'(1);
      end
    end
  end

  // Leave INIT on the cycle the last entry is being cleared; RUN is sticky.
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && clr_last) begin
      state_d = RUN;
    end
  end

  // Array update: clearing during INIT, otherwise in-range writes only.
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_fire && wr_in_range) begin
      mem[wr_addr_i[CNT_W-1:0]] <= wr_data_i;
    end
  end

  // Sample the array at acceptance; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr_i[CNT_W-1:0]];
    end
  end

  regfile_rd_pipe #(
    .LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk_i),
    .arst      (arst_i),
    .in_valid  (rd_fire),
    .in_err    (!rd_in_range),
    .in_data   (rd_word),
    .out_valid (rd_data_valid_o),
    .out_err   (rd_err_o),
    .out_data  (rd_data_o)
  );

endmodule

// File: tb/tb_operand_regfile.sv
// Directed bench for operand_regfile with DEPTH=32, RD_LATENCY=2.
module tb_operand_regfile;
  import config_pkg::*;

  localparam int DEPTH = 32;
  localparam int RL    = 2;

  logic  clk;
  logic  arst;
  addr_t rd_addr;
  logic  rd_addr_valid;
  logic  rd_addr_ready;
  data_t rd_data;
  logic  rd_data_valid;
  logic  rd_err;
  addr_t wr_addr;
  data_t wr_data;
  logic  wr_valid;
  logic  wr_ready;
  logic  init_done;

  int    checks;
  int    errors;
  data_t exp_mem [DEPTH];

  operand_regfile #(
    .DEPTH      (DEPTH),
    .RD_LATENCY (RL)
  ) dut (
    .clk_i           (clk),
    .arst_i          (arst),
    .rd_addr_i       (rd_addr),
    .rd_addr_valid_i (rd_addr_valid),
    .rd_addr_ready_o (rd_addr_ready),
    .rd_data_o       (rd_data),
    .rd_data_valid_o (rd_data_valid),
    .rd_err_o        (rd_err),
    .wr_addr_i       (wr_addr),
    .wr_data_i       (wr_data),
    .wr_valid_i      (wr_valid),
    .wr_ready_o      (wr_ready),
    .init_done_o     (init_done)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input addr_t wa, input data_t wd,
                               input logic rv, input addr_t ra);
    wr_valid      = wv;
    wr_addr       = wa;
    wr_data       = wd;
    rd_addr_valid = rv;
    rd_addr       = ra;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = '0;
    end
  endtask

  // One write cycle; the model ignores out-of-range addresses.
  task automatic writeWord(input int addr, input data_t data);
    applyStimulus(1'b1, addr_t'(addr), data, 1'b0, '0);
    tick();
    if (addr < DEPTH) begin
      exp_mem[addr] = data;
    end
  endtask

  // Wait for init_done with a cycle budget and check the init length.
  task automatic waitInit(input string tag);
    int   cycles;
    logic saw_valid;
    cycles    = 0;
    saw_valid = 1'b0;
    while (!init_done && cycles < 200) begin
      tick();
      cycles++;
      saw_valid = saw_valid | rd_data_valid;
    end
    checkOutput({tag, "_init_cycles"}, cycles, DEPTH);
    checkOutput({tag, "_no_valid_in_init"}, saw_valid, 1'b0);
  endtask

  // Back-to-back reads starting at 'start'; each return is checked the
  // RL-th sample after its acceptance, and the port must go quiet after.
  task automatic readStream(input int start, input int count, input string tag);
    int r;
    int a;
    for (int s = 0; s < count + RL + 1; s++) begin
      if (s < count) begin
        applyStimulus(1'b0, '0, '0, 1'b1, addr_t'(start + s));
      end else begin
        idle();
      end
      #1;
      if (s < count) begin
        checkOutput($sformatf("%s_ready[%0d]", tag, s), rd_addr_ready, 1'b1);
      end
      r = s - RL;
      if (r >= 0 && r < count) begin
        a = start + r;
        checkOutput($sformatf("%s_valid[%0d]", tag, a), rd_data_valid, 1'b1);
        checkOutput($sformatf("%s_err[%0d]", tag, a), rd_err, (a >= DEPTH) ? 1'b1 : 1'b0);
        checkOutput($sformatf("%s_data[%0d]", tag, a), rd_data,
                    (a < DEPTH) ? exp_mem[a] : 32'h0);
      end else begin
        checkOutput($sformatf("%s_quiet[%0d]", tag, s), rd_data_valid, 1'b0);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearModel();
    idle();

    // Reset values.
    arst = 1'b1;
    tick();
    tick();
    checkOutput("rst_rd_ready", rd_addr_ready, 1'b0);
    checkOutput("rst_wr_ready", wr_ready, 1'b0);
    checkOutput("rst_init_done", init_done, 1'b0);
    checkOutput("rst_rd_valid", rd_data_valid, 1'b0);
    checkOutput("rst_rd_err", rd_err, 1'b0);
    checkOutput("rst_rd_data", rd_data, 32'h0);

    // Init sequence, then every entry reads back as zero.
    arst = 1'b0;
    waitInit("boot");
    checkOutput("boot_wr_ready", wr_ready, 1'b1);
    readStream(0, DEPTH, "zeros");

    // Write then read on the very next cycle.
    writeWord(5, 32'hDEAD_BEEF);
    readStream(5, 1, "raw");

    // Write/read collision: writes hold off the read for three cycles.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, addr_t'(9), data_t'(32'h1111_1111 * i), 1'b1, addr_t'(9));
      #1;
      checkOutput($sformatf("collide_ready[%0d]", i), rd_addr_ready, 1'b0);
      checkOutput($sformatf("collide_wr_ready[%0d]", i), wr_ready, 1'b1);
      tick();
      exp_mem[9] = data_t'(32'h1111_1111 * i);
    end
    readStream(9, 1, "collide_rd");
    checkOutput("collide_last_word", rd_data, 32'h3333_3333);

    // Streaming: preload addr*3 then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      writeWord(i, data_t'(i * 3));
    end
    idle();
    tick();
    readStream(0, 16, "stream");
    checkOutput("stream_last_word", rd_data, 32'd45);

    // Out-of-range read and write.
    readStream(40, 1, "oor_rd");
    writeWord(40, 32'hBAD0_BAD0);
    idle();
    tick();
    readStream(0, DEPTH, "oor_wr_all");

    // Reset with reads in flight: one accepted, one being presented.
    writeWord(20, 32'hCAFE_F00D);
    applyStimulus(1'b0, '0, '0, 1'b1, addr_t'(20));
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, addr_t'(21));
    #2;
    arst = 1'b1;
    #1;
    checkOutput("midrst_valid_now", rd_data_valid, 1'b0);
    checkOutput("midrst_ready_now", rd_addr_ready, 1'b0);
    idle();
    tick();
    checkOutput("midrst_valid_1", rd_data_valid, 1'b0);
    tick();
    checkOutput("midrst_valid_2", rd_data_valid, 1'b0);
    clearModel();
    arst = 1'b0;
    waitInit("midrst");
    readStream(20, 1, "midrst_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
